// File: rtl/mul_iter_unit_if.sv
// mul_iter_unit_if: request/response bundle between the controller and the iterative multiplier.
interface mul_iter_unit_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [1:0]       MulCtrl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic             Stall;
    modport master (output Start, MulCtrl, SrcA, SrcB, input Busy, Done, ResultLo, ResultHi, Stall);
    modport slave (input Start, MulCtrl, SrcA, SrcB, output Busy, Done, ResultLo, ResultHi, Stall);
endinterface

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: shift-add multiplier, one iteration per cycle, MUL/UMULL/SMULL.
// SMULL runs on magnitudes and applies the sign to the 2*WIDTH-bit product on entry to DONE.
module mul_iter_unit #(parameter int WIDTH = 32) (
    input logic            clk,
    input logic            reset,
    mul_iter_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, lo_q, lo_d, hi_q, hi_d;
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic neg_q, neg_d;
    logic accept, smull, long_q;
    logic [WIDTH:0] sum;
    logic [2*WIDTH-1:0] prod;
    assign accept = bus.Start && (state_q == IDLE || state_q == DONE);
    assign smull = bus.MulCtrl == 2'b10;
    assign long_q = ctrl_q == 2'b01 || ctrl_q == 2'b10;
    assign sum = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign prod = neg_q ? ~acc_q[2*WIDTH-1:0] + 1'b1 : acc_q[2*WIDTH-1:0];
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        ctrl_d = ctrl_q;
        neg_d = neg_q;
        lo_d = lo_q;
        hi_d = hi_q;
        if (accept) begin
            state_d = RUN;
            ctrl_d = bus.MulCtrl;
            mcand_d = smull && bus.SrcA[WIDTH-1] ? ~bus.SrcA + 1'b1 : bus.SrcA;
            mplier_d = smull && bus.SrcB[WIDTH-1] ? ~bus.SrcB + 1'b1 : bus.SrcB;
            neg_d = smull && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            if (cnt_q == CW'(WIDTH)) begin
                state_d = DONE;
                lo_d = prod[WIDTH-1:0];
                hi_d = long_q ? prod[2*WIDTH-1:WIDTH] : '0;
            end else begin
                acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + CW'(1);
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplier_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            ctrl_q <= '0;
            neg_q <= 1'b0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ctrl_q <= ctrl_d;
            neg_q <= neg_d;
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end
    assign bus.Busy = state_q == RUN;
    assign bus.Done = state_q == DONE;
    assign bus.ResultLo = lo_q;
    assign bus.ResultHi = hi_q;
    assign bus.Stall = accept || state_q == RUN;
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: directed multiplies; expectations queued at issue, checked when Done appears.
module tb_mul_iter_unit;
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          acc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    mul_iter_unit_if #(.WIDTH(32)) bus ();
    mul_iter_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && bus.Done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("result_lo", bus.ResultLo, e.lo);
                chk("result_hi", bus.ResultHi, e.hi);
                chk("latency", cyc - e.acc, 33);
                chk("busy_with_done", bus.Busy, 0);
            end
        end
    end
    // Caller must be between a negedge and the following posedge.
    task automatic issue(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input bit push);
        bus.Start = 1'b1;
        bus.MulCtrl = ctrl;
        bus.SrcA = a;
        bus.SrcB = b;
        if (push) exp_q.push_back('{lo, hi, cyc + 1});
        #1 chk("stall_on_accept", bus.Stall, 1);
        @(posedge clk);
        #1 bus.Start = 1'b0;
    endtask
    task automatic run_wait(input int inject_at);
        bit seen = 0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(negedge clk);
            bus.Start = (n == inject_at);
            if (n == inject_at) begin
                bus.SrcA = 32'd3;
                bus.SrcB = 32'd3;
            end
            #1;
            if (bus.Done) seen = 1;
            else begin
                chk("busy_in_run", bus.Busy, 1);
                chk("stall_in_run", bus.Stall, 1);
            end
        end
        bus.Start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask
    task automatic op(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lo, input logic [31:0] hi);
        @(negedge clk);
        issue(ctrl, a, b, lo, hi, 1);
        run_wait(0);
        @(negedge clk);
        #1 chk("done_one_cycle", bus.Done, 0);
        chk("lo_held", bus.ResultLo, lo);
        chk("hi_held", bus.ResultHi, hi);
    endtask
    initial begin
        bit late_done = 0;
        bus.Start = 1'b0;
        bus.MulCtrl = 2'b00;
        bus.SrcA = '0;
        bus.SrcB = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_lo", bus.ResultLo, 0);
        chk("rst_hi", bus.ResultHi, 0);
        chk("rst_stall", bus.Stall, 0);
        reset = 1'b1;
        op(2'b00, 32'd7, 32'd6, 32'h2A, 32'h0);
        op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
        op(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF);
        op(2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000);
        op(2'b10, 32'h80000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF);
        op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0);
        op(2'b01, 32'h12345678, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        issue(2'b00, 32'd10, 32'd10, 32'd100, 32'h0, 1);
        run_wait(5);
        repeat (40) @(negedge clk);
        chk("lo_after_ignored_start", bus.ResultLo, 100);
        @(negedge clk);
        issue(2'b01, 32'd5, 32'd5, 32'd25, 32'h0, 0);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("abort_busy", bus.Busy, 0);
        chk("abort_done", bus.Done, 0);
        chk("abort_lo", bus.ResultLo, 0);
        chk("abort_hi", bus.ResultHi, 0);
        chk("abort_stall", bus.Stall, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.Done) late_done = 1;
        end
        chk("no_done_after_abort", late_done, 0);
        op(2'b10, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF);
        @(negedge clk);
        issue(2'b01, 32'd2, 32'd3, 32'd6, 32'h0, 1);
        run_wait(0);
        issue(2'b00, 32'h0, 32'h12345678, 32'h0, 32'h0, 1);
        #1 chk("b2b_no_idle", bus.Busy, 1);
        run_wait(0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
